// File: rtl/taint_rom_requester_pkg.sv
// Shared types and constants for the taint-carrying boot-ROM read path.
// Used by the requester, its response FIFO and the ROM model.
package taint_rom_pkg;

   localparam int unsigned ROM_WORD_BYTES     = 4;
   localparam logic [31:0] DEF_ADDR_OFFSET    = 32'h0000_0000;
   localparam int unsigned DEF_ROM_ADDR_WIDTH = 15;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] taint;
      logic        err;
   } rom_resp_t;

endpackage

// File: rtl/taint_rom_requester_if.sv
// Handshake bundles: client request/response (taint_req_if) and ROM bus (taint_rom_if).
// master = initiator side of each bundle, slave = target side.
interface taint_req_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_valid_t0_i;
   logic [31:0] req_addr_t0_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_data_o;
   logic [31:0] resp_data_t0_o;
   logic        resp_err_o;

   modport master (
      output req_valid_i, req_addr_i, req_valid_t0_i, req_addr_t0_i,
      output resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_data_t0_o,
      input  resp_err_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_valid_t0_i, req_addr_t0_i,
      input  resp_ready_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_data_t0_o,
      output resp_err_o
   );
endinterface

interface taint_rom_if;
   logic        csn;
   logic [31:0] add;
   logic        wen;
   logic [31:0] be;
   logic [31:0] wdata;
   logic [3:0]  id;
   logic        csn_t0;
   logic [31:0] add_t0;
   logic        wen_t0;
   logic [31:0] be_t0;
   logic [31:0] wdata_t0;
   logic [3:0]  id_t0;
   logic [31:0] rdata;
   logic [31:0] rdata_t0;

   modport master (
      output csn, add, wen, be, wdata, id,
      output csn_t0, add_t0, wen_t0, be_t0, wdata_t0, id_t0,
      input  rdata, rdata_t0
   );

   modport slave (
      input  csn, add, wen, be, wdata, id,
      input  csn_t0, add_t0, wen_t0, be_t0, wdata_t0, id_t0,
      output rdata, rdata_t0
   );
endinterface

// File: rtl/taint_rom_requester_resp_fifo.sv
// Circular response buffer with registered head; empty head reads as zero.
// Ports: clk_i, rst_i, push_i/data_i, pop_i, valid_o/data_o, count_o.
module taint_resp_fifo
   import taint_rom_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter type T = rom_resp_t,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  T                data_i,
   input  logic            pop_i,
   output logic            valid_o,
   output T                data_o,
   output logic [CntW-1:0] count_o
);

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("taint_resp_fifo: Depth must be a power of two >= 2");
   end

   T                mem [Depth];
   logic [PtrW-1:0] wr_q;
   logic [PtrW-1:0] rd_q;
   logic [CntW-1:0] cnt_q;
   logic            pop;

   assign pop     = pop_i && (cnt_q != '0);
   assign valid_o = (cnt_q != '0);
   assign data_o  = valid_o ? mem[rd_q] : '0;
   assign count_o = cnt_q;

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PtrW'(1);
         if (pop)    rd_q <= rd_q + PtrW'(1);
         if (push_i && !pop)      cnt_q <= cnt_q + CntW'(1);
         else if (pop && !push_i) cnt_q <= cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_q] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push_i && cnt_q == CntW'(Depth)))
            else $error("taint_resp_fifo: push into full FIFO");
      end
   end

endmodule

// File: rtl/taint_rom_requester.sv
// Boot-ROM read requester with taint shadows; in-order responses via a small FIFO.
// Ports: clk_i, rst_i, req (client handshake, slave), rom (ROM bus, master).
module taint_rom_requester
   import taint_rom_pkg::*;
#(
   parameter logic [31:0] AddrOffset    = DEF_ADDR_OFFSET,
   parameter int unsigned RomAddrWidth  = DEF_ROM_ADDR_WIDTH,
   parameter bit          ByteAddressed = 1'b1,
   parameter int unsigned FifoDepth     = 2,
   parameter int unsigned NumTaints     = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   taint_req_if.slave  req,
   taint_rom_if.master rom
);

   if (NumTaints != 1) begin : g_bad_taints
      $error("taint_rom_requester: only NumTaints == 1 is supported");
   end

   localparam int unsigned CntW     = $clog2(FifoDepth + 1);
   localparam logic [32:0] WinBytes = 33'(ROM_WORD_BYTES) << RomAddrWidth;
   localparam int unsigned IdxW     = ByteAddressed ? RomAddrWidth + 2
                                                    : RomAddrWidth;
   localparam logic [31:0] IdxMask  = 32'((33'd1 << IdxW) - 33'd1);

   logic [31:0]   off;
   logic [31:0]   idx;
   logic          ok;
   logic [CntW:0] inflight;
   logic          rdy;
   logic          accept;
   logic          issue;

   logic          s1_valid_q;
   logic          s1_err_q;
   logic          s1_taint_q;

   logic [CntW-1:0] cnt;
   rom_resp_t       push_d;
   rom_resp_t       head;

   // A wrapped subtraction is caught by the >= term.
   always_comb begin
      off      = req.req_addr_i - AddrOffset;
      ok       = (req.req_addr_i >= AddrOffset)
              && ({1'b0, off} < WinBytes)
              && (!ByteAddressed || req.req_addr_i[1:0] == 2'b00);
      idx      = ByteAddressed ? off : (off >> 2);
      // Credit counts the s1 slot so an accepted request always finds room.
      inflight = {1'b0, cnt} + (CntW+1)'(s1_valid_q);
      rdy      = !rst_i && (inflight < (CntW+1)'(FifoDepth));
      accept   = req.req_valid_i && rdy;
      issue    = accept && ok;
   end

   assign req.req_ready_o = rdy;

   assign rom.csn      = !issue;
   assign rom.add      = issue ? (idx & IdxMask) : '0;
   assign rom.wen      = 1'b1;
   assign rom.be       = '1;
   assign rom.wdata    = '0;
   assign rom.id       = '0;
   assign rom.csn_t0   = req.req_valid_t0_i;
   assign rom.add_t0   = issue ? req.req_addr_t0_i : '0;
   assign rom.wen_t0   = 1'b0;
   assign rom.be_t0    = '0;
   assign rom.wdata_t0 = '0;
   assign rom.id_t0    = '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_taint_q <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_err_q   <= !ok;
            s1_taint_q <= |req.req_addr_t0_i | req.req_valid_t0_i;
         end
      end
   end

   // A tainted address or valid makes the whole word suspect.
   always_comb begin
      push_d.data  = s1_err_q ? '0 : rom.rdata;
      push_d.taint = (s1_err_q ? '0 : rom.rdata_t0) | {32{s1_taint_q}};
      push_d.err   = s1_err_q;
   end

   taint_resp_fifo #(
      .Depth (FifoDepth),
      .T     (rom_resp_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (s1_valid_q),
      .data_i  (push_d),
      .pop_i   (req.resp_ready_i),
      .valid_o (req.resp_valid_o),
      .data_o  (head),
      .count_o (cnt)
   );

   assign req.resp_data_o    = head.data;
   assign req.resp_data_t0_o = head.taint;
   assign req.resp_err_o     = head.err;

endmodule

// File: tb/tb_taint_rom_requester.sv
// Directed bench for taint_rom_requester with a 1-cycle-latency ROM model.
// Window at 0x10000, byte addressed, FifoDepth 2.
module tb_taint_rom_requester;
   import taint_rom_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   taint_req_if rq ();
   taint_rom_if rm ();

   taint_rom_requester #(
      .AddrOffset    (32'h0001_0000),
      .RomAddrWidth  (15),
      .ByteAddressed (1'b1),
      .FifoDepth     (2),
      .NumTaints     (1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .req   (rq),
      .rom   (rm)
   );

   localparam logic [31:0] ROMD [8] = '{
      32'h1111_0000, 32'h2222_1111, 32'hDEAD_BEEF, 32'h4444_3333,
      32'h5555_4444, 32'h6666_5555, 32'h7777_6666, 32'h8888_7777
   };
   localparam logic [31:0] ROMT [8] = '{
      32'h0, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
   };

   // Garbage when deselected so error slots must come back as zero.
   always @(posedge clk) begin
      if (!rm.csn) begin
         rm.rdata    <= ROMD[rm.add[4:2]];
         rm.rdata_t0 <= ROMT[rm.add[4:2]];
      end else begin
         rm.rdata    <= 32'hBAD0_BAD0;
         rm.rdata_t0 <= 32'h5A5A_0000;
      end
   end

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [31:0] va [4];
   logic [31:0] vd [4];
   logic [31:0] vt [4];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a,
                        input logic [31:0] at0, input logic vt0);
      rq.req_valid_i    = v;
      rq.req_addr_i     = a;
      rq.req_addr_t0_i  = at0;
      rq.req_valid_t0_i = vt0;
   endtask

   task automatic single_read(input string tag, input logic [31:0] a,
                              input logic [31:0] at0, input logic vt0,
                              input logic ecsn, input logic [31:0] eadd,
                              input logic [31:0] eat0,
                              input logic [31:0] ed, input logic [31:0] et,
                              input logic ee);
      @(negedge clk);
      drive(1'b1, a, at0, vt0);
      #1;
      chk({tag, "_rdy"},   32'(rq.req_ready_o), 32'd1);
      chk({tag, "_csn"},   32'(rm.csn), 32'(ecsn));
      chk({tag, "_add"},   rm.add, eadd);
      chk({tag, "_addt0"}, rm.add_t0, eat0);
      chk({tag, "_csnt0"}, 32'(rm.csn_t0), 32'(vt0));
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk({tag, "_lat1"},  32'(rq.resp_valid_o), 32'd0);
      @(negedge clk);
      #1;
      chk({tag, "_rv"},    32'(rq.resp_valid_o), 32'd1);
      chk({tag, "_data"},  rq.resp_data_o, ed);
      chk({tag, "_taint"}, rq.resp_data_t0_o, et);
      chk({tag, "_err"},   32'(rq.resp_err_o), 32'(ee));
   endtask

   // Fixed schedule for four back-to-back offers with FifoDepth 2 and
   // resp_ready high: ready 1,1,0,1,1,0,1; responses at cycles 2,3,5,6.
   task automatic burst4(input string tag, input logic [3:0] ee);
      bit er [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int ri [7] = '{-1, -1, 0, 1, -1, 2, 3};
      int nx = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (nx < 4) drive(1'b1, va[nx], 32'h0, 1'b0);
         else        drive(1'b0, 32'h0, 32'h0, 1'b0);
         #1;
         chk($sformatf("%s_rdy%0d", tag, c), 32'(rq.req_ready_o), 32'(er[c]));
         if (nx < 4)
            chk($sformatf("%s_csn%0d", tag, c), 32'(rm.csn),
                32'((er[c] && !ee[nx]) ? 1'b0 : 1'b1));
         chk($sformatf("%s_rv%0d", tag, c), 32'(rq.resp_valid_o),
             32'(ri[c] >= 0));
         if (ri[c] >= 0) begin
            chk($sformatf("%s_d%0d", tag, ri[c]), rq.resp_data_o, vd[ri[c]]);
            chk($sformatf("%s_t%0d", tag, ri[c]), rq.resp_data_t0_o, vt[ri[c]]);
            chk($sformatf("%s_e%0d", tag, ri[c]), 32'(rq.resp_err_o),
                32'(ee[ri[c]]));
         end
         if (nx < 4 && rq.req_ready_o) nx++;
      end
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      rq.resp_ready_i = 1'b1;
      #1;
      chk("rst_rdy",   32'(rq.req_ready_o), 32'd0);
      chk("rst_csn",   32'(rm.csn), 32'd1);
      chk("rst_add",   rm.add, 32'h0);
      chk("rst_rv",    32'(rq.resp_valid_o), 32'd0);
      chk("rst_data",  rq.resp_data_o, 32'h0);
      chk("rst_taint", rq.resp_data_t0_o, 32'h0);
      chk("rst_err",   32'(rq.resp_err_o), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_rdy", 32'(rq.req_ready_o), 32'd1);

      // Single read plus constant bus fields
      single_read("rd1", 32'h0001_0008, 32'h0, 1'b0, 1'b0, 32'h8, 32'h0,
                  32'hDEAD_BEEF, 32'h0, 1'b0);
      chk("wen",   32'(rm.wen), 32'd1);
      chk("be",    rm.be, 32'hFFFF_FFFF);
      chk("wdata", rm.wdata, 32'h0);
      chk("id",    32'(rm.id), 32'd0);
      chk("bet0",  rm.be_t0, 32'h0);

      // Taint propagation and window edges
      single_read("tnt_a", 32'h0001_0000, 32'h1, 1'b0, 1'b0, 32'h0, 32'h1,
                  32'h1111_0000, 32'hFFFF_FFFF, 1'b0);
      single_read("tnt_r", 32'h0001_0004, 32'h0, 1'b0, 1'b0, 32'h4, 32'h0,
                  32'h2222_1111, 32'h0000_00FF, 1'b0);
      single_read("tnt_v", 32'h0001_000C, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0,
                  32'h4444_3333, 32'hFFFF_FFFF, 1'b0);
      single_read("last", 32'h0002_FFFC, 32'h0, 1'b0, 1'b0, 32'h1_FFFC, 32'h0,
                  32'h8888_7777, 32'h0, 1'b0);
      single_read("above", 32'h0003_0000, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0,
                  32'h0, 32'h0, 1'b1);
      single_read("err_t", 32'h0000_FFFC, 32'h3, 1'b0, 1'b1, 32'h0, 32'h0,
                  32'h0, 32'hFFFF_FFFF, 1'b1);

      // Back-to-back reads
      va = '{32'h0001_0000, 32'h0001_0004, 32'h0001_0008, 32'h0001_000C};
      vd = '{ROMD[0], ROMD[1], ROMD[2], ROMD[3]};
      vt = '{32'h0, 32'h0000_00FF, 32'h0, 32'h0};
      burst4("b2b", 4'b0000);

      // Errors sandwiched between valid reads
      va = '{32'h0001_0004, 32'h0000_FFFC, 32'h0001_0002, 32'h0001_0008};
      vd = '{ROMD[1], 32'h0, 32'h0, ROMD[2]};
      vt = '{32'h0000_00FF, 32'h0, 32'h0, 32'h0};
      burst4("errs", 4'b0110);

      // Backpressure
      @(negedge clk);
      rq.resp_ready_i = 1'b0;
      drive(1'b1, 32'h0001_0008, 32'h0, 1'b0);
      #1 chk("bp_rdy0", 32'(rq.req_ready_o), 32'd1);
      @(negedge clk);
      drive(1'b1, 32'h0001_000C, 32'h0, 1'b0);
      #1 chk("bp_rdy1", 32'(rq.req_ready_o), 32'd1);
      @(negedge clk);
      drive(1'b1, 32'h0001_0004, 32'h0, 1'b0);
      #1;
      chk("bp_rdy2", 32'(rq.req_ready_o), 32'd0);
      chk("bp_csn2", 32'(rm.csn), 32'd1);
      chk("bp_rv2",  32'(rq.resp_valid_o), 32'd1);
      chk("bp_d2",   rq.resp_data_o, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      chk("bp_rdy3",  32'(rq.req_ready_o), 32'd0);
      chk("bp_hold3", rq.resp_data_o, 32'hDEAD_BEEF);
      rq.resp_ready_i = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_rdy4", 32'(rq.req_ready_o), 32'd1);
      chk("bp_d4",   rq.resp_data_o, 32'h4444_3333);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1 chk("bp_rv5", 32'(rq.resp_valid_o), 32'd0);
      @(negedge clk);
      #1;
      chk("bp_rv6", 32'(rq.resp_valid_o), 32'd1);
      chk("bp_d6",  rq.resp_data_o, 32'h2222_1111);
      chk("bp_t6",  rq.resp_data_t0_o, 32'h0000_00FF);
      @(negedge clk);
      #1 chk("bp_rv7", 32'(rq.resp_valid_o), 32'd0);

      // Reset with one entry queued and one in s1
      rq.resp_ready_i = 1'b0;
      drive(1'b1, 32'h0001_0008, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h0001_000C, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h0001_0000, 32'h0, 1'b0);
      #1 chk("mr_rv_pre", 32'(rq.resp_valid_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mr_rv",   32'(rq.resp_valid_o), 32'd0);
      chk("mr_data", rq.resp_data_o, 32'h0);
      chk("mr_rdy",  32'(rq.req_ready_o), 32'd0);
      chk("mr_csn",  32'(rm.csn), 32'd1);
      chk("mr_add",  rm.add, 32'h0);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      rq.resp_ready_i = 1'b1;
      #1 chk("mr_rel_rdy", 32'(rq.req_ready_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk($sformatf("mr_stale%0d", i), 32'(rq.resp_valid_o), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
